// File: rtl/exibe_sequencia_if.sv
// Signal bundle between the sequence presenter and its controller/ROM side.
// The abortar line exists only when EXIBE_ABORT_EN is defined.
interface exibe_sequencia_if #(
  parameter int W_END  = 4,
  parameter int W_DADO = 4
);
  logic              iniciar;
  logic [W_END-1:0]  limite;
  logic [W_DADO-1:0] dado;
  logic [W_END-1:0]  endereco;
  logic [W_DADO-1:0] leds;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;
`ifdef EXIBE_ABORT_EN
  logic              abortar;

  modport master (output iniciar, limite, dado, abortar,
                  input  endereco, leds, ocupado, pronto, db_estado);
  modport slave  (input  iniciar, limite, dado, abortar,
                  output endereco, leds, ocupado, pronto, db_estado);
`else
  modport master (output iniciar, limite, dado,
                  input  endereco, leds, ocupado, pronto, db_estado);
  modport slave  (input  iniciar, limite, dado,
                  output endereco, leds, ocupado, pronto, db_estado);
`endif
endinterface

// File: rtl/exibe_sequencia.sv
// Shows the stored game sequence on the LEDs, item by item, then pulses pronto.
// Optional feature: EXIBE_ABORT_EN adds an abortar input that jumps straight to fim.
module exibe_sequencia #(
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500,
  parameter int W_END  = 4,
  parameter int W_DADO = 4
) (
  input  logic clock,
  input  logic reset,
  exibe_sequencia_if.slave bus
);
  localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    BUSCA   = 4'h1,
    MOSTRA  = 4'h2,
    APAGA   = 4'h3,
    PROXIMO = 4'h4,
    FIM     = 4'hF
  } estado_t;

  estado_t            state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [W_END-1:0]   end_q, end_d;
  logic [W_END-1:0]   lim_q, lim_d;
  logic [W_DADO-1:0]  leds;
  logic               pronto, ocupado;
  logic [3:0]         db_estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      timer_q <= '0;
      end_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      end_q   <= end_d;
      lim_q   <= lim_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    end_d     = end_q;
    lim_d     = lim_q;
    leds      = '0;
    pronto    = 1'b0;
    ocupado   = 1'b1;
    db_estado = state_q;
    case (state_q)
      INICIAL: begin
        ocupado = 1'b0;
        if (bus.iniciar) begin
          state_d = BUSCA;
          lim_d   = bus.limite;
          end_d   = '0;
          timer_d = '0;
        end
      end
      BUSCA: begin
        state_d = MOSTRA;
        timer_d = '0;
      end
      MOSTRA: begin
        leds = bus.dado;
        if (timer_q == ON_LAST) begin
          state_d = APAGA;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      APAGA: begin
        if (timer_q == OFF_LAST) begin
          state_d = PROXIMO;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PROXIMO: begin
        timer_d = '0;
        // Compare before incrementing so a full-range limit never wraps endereco.
        if (end_q == lim_q) begin
          state_d = FIM;
        end else begin
          end_d   = end_q + 1'b1;
          state_d = BUSCA;
        end
      end
      FIM: begin
        pronto  = 1'b1;
        end_d   = '0;
        state_d = INICIAL;
      end
      default: begin
        state_d   = INICIAL;
        db_estado = 4'hE;
      end
    endcase
`ifdef EXIBE_ABORT_EN
    // Abort overrides any timer expiry taken in the case above.
    if (bus.abortar && (state_q inside {BUSCA, MOSTRA, APAGA, PROXIMO})) begin
      state_d = FIM;
      timer_d = '0;
    end
`endif
  end

  assign bus.endereco  = end_q;
  assign bus.leds      = leds;
  assign bus.pronto    = pronto;
  assign bus.ocupado   = ocupado;
  assign bus.db_estado = db_estado;
endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia: stimulus queues expected LED runs and pronto pulses.
module tb_exibe_sequencia;
  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int ITEM  = 2 + T_ON + T_OFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exibe_sequencia_if #(.W_END(4), .W_DADO(4)) b1 ();
  exibe_sequencia_if #(.W_END(2), .W_DADO(4)) b2 ();

  exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .W_END(4), .W_DADO(4))
    dut1 (.clock(clk), .reset(rst_n), .bus(b1));
  exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .W_END(2), .W_DADO(4))
    dut2 (.clock(clk), .reset(rst_n), .bus(b2));

  logic [3:0] rom1 [16];
  logic [3:0] rom2 [4];
  always @(posedge clk) begin
    b1.dado <= rom1[b1.endereco];
    b2.dado <= rom2[b2.endereco];
  end

  typedef struct {
    bit         is_pronto;
    logic [3:0] val;
    int         addr;
    int         start;
    int         len;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sel = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_exp(input bit use2, input int lim, input int c);
    for (int i = 0; i <= lim; i++)
      q.push_back('{1'b0, use2 ? rom2[i] : rom1[i], i, c + 2 + i * ITEM, T_ON});
    q.push_back('{1'b1, 4'd0, 0, c + 1 + (lim + 1) * ITEM, 0});
  endfunction

  logic [3:0] leds_m, addr_m;
  logic pr_m, ocup_m;
  logic [3:0] db_m;
  always_comb begin
    leds_m = sel ? b2.leds : b1.leds;
    addr_m = sel ? {2'b00, b2.endereco} : b1.endereco;
    pr_m   = sel ? b2.pronto : b1.pronto;
    ocup_m = sel ? b2.ocupado : b1.ocupado;
    db_m   = sel ? b2.db_estado : b1.db_estado;
  end

  // Monitor: collapses each nonzero LED run into one observation and pops the scoreboard.
  int run_len = 0, run_start = 0, run_addr = 0;
  logic [3:0] run_val = '0;
  bit run_bad = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if (leds_m != 0) begin
        if (run_len == 0) begin
          run_start = cyc; run_val = leds_m; run_addr = int'(addr_m); run_bad = 1'b0;
        end else if (leds_m != run_val) run_bad = 1'b1;
        run_len++;
      end else if (run_len > 0) begin
        if (q.size() == 0) chk("unexpected_item", 1, 0);
        else begin
          e = q.pop_front();
          chk("item_kind", int'(e.is_pronto), 0);
          chk("item_val", int'(run_val), int'(e.val));
          chk("item_addr", run_addr, e.addr);
          chk("item_start", run_start, e.start);
          chk("item_len", run_len, e.len);
          chk("item_steady", int'(run_bad), 0);
        end
        run_len = 0;
      end
      if (pr_m) begin
        if (q.size() == 0) chk("unexpected_pronto", 1, 0);
        else begin
          e = q.pop_front();
          chk("pronto_kind", int'(e.is_pronto), 1);
          chk("pronto_cycle", cyc, e.start);
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!ocup_m) begin
        chk({nm, "_db_idle"}, int'(db_m), 0);
        chk({nm, "_addr_idle"}, int'(addr_m), 0);
        chk({nm, "_drained"}, q.size(), 0);
        return;
      end
    end
    chk({nm, "_timeout"}, 1, 0);
    q.delete();
  endtask

  task automatic go(input bit use2, input int lim);
    if (use2) begin b2.limite = 2'(lim); b2.iniciar = 1'b1; end
    else begin b1.limite = 4'(lim); b1.iniciar = 1'b1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 16; i++) rom1[i] = 4'd9;
    rom1[0] = 4'd3; rom1[1] = 4'd7; rom1[2] = 4'd1;
    rom2[0] = 4'd2; rom2[1] = 4'd4; rom2[2] = 4'd6; rom2[3] = 4'd8;
    b1.iniciar = 1'b0; b1.limite = '0;
    b2.iniciar = 1'b0; b2.limite = '0;
`ifdef EXIBE_ABORT_EN
    b1.abortar = 1'b0; b2.abortar = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_leds", int'(b1.leds), 0);
    chk("rst_addr", int'(b1.endereco), 0);
    chk("rst_db", int'(b1.db_estado), 0);
    chk("rst_ocupado", int'(b1.ocupado), 0);
    chk("rst_pronto", int'(b1.pronto), 0);
    #2 rst_n = 1'b1;

    // Nominal run, with a stray iniciar while busy.
    @(negedge clk); c = cyc; push_exp(0, 2, c); go(0, 2);
    @(negedge clk); b1.iniciar = 1'b0;
    chk("nom_db_busca", int'(b1.db_estado), 1);
    chk("nom_ocupado", int'(b1.ocupado), 1);
    while (cyc < c + 5) @(negedge clk);
    b1.iniciar = 1'b1;
    @(negedge clk); b1.iniciar = 1'b0;
    wait_idle("nominal");

    // limite = 0
    @(negedge clk); c = cyc; push_exp(0, 0, c); go(0, 0);
    @(negedge clk); b1.iniciar = 1'b0;
    wait_idle("lim0");

    // iniciar held high, limite dropped mid-show, immediate restart after fim
    @(negedge clk); c = cyc; push_exp(0, 2, c); push_exp(0, 0, c + 26); go(0, 2);
    while (cyc < c + 3) @(negedge clk);
    b1.limite = 4'd0;
    while (cyc < c + 27) @(negedge clk);
    b1.iniciar = 1'b0;
    wait_idle("held");

    // Narrow address space: full ROM shown without wrap
    sel = 1'b1;
    @(negedge clk); c = cyc; push_exp(1, 3, c); go(1, 3);
    @(negedge clk); b2.iniciar = 1'b0;
    wait_idle("fullrom");
    sel = 1'b0;

`ifdef EXIBE_ABORT_EN
    @(negedge clk); c = cyc;
    q.push_back('{1'b0, rom1[0], 0, c + 2, T_ON});
    q.push_back('{1'b0, rom1[1], 1, c + 10, 2});
    q.push_back('{1'b1, 4'd0, 0, c + 12, 0});
    go(0, 2);
    @(negedge clk); b1.iniciar = 1'b0;
    while (cyc < c + 11) @(negedge clk);
    b1.abortar = 1'b1;
    @(negedge clk); b1.abortar = 1'b0;
    chk("abort_leds", int'(b1.leds), 0);
    chk("abort_db", int'(b1.db_estado), 15);
    wait_idle("abort");
`endif

    // Asynchronous reset while an item is on the LEDs
    rom1[0] = 4'd5;
    @(negedge clk); c = cyc; go(0, 0);
    @(negedge clk); b1.iniciar = 1'b0;
    while (cyc < c + 3) @(negedge clk);
    chk("pre_rst_leds", int'(b1.leds), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_leds", int'(b1.leds), 0);
    chk("async_addr", int'(b1.endereco), 0);
    chk("async_db", int'(b1.db_estado), 0);
    chk("async_pronto", int'(b1.pronto), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ocupado", int'(b1.ocupado), 0);
    chk("post_rst_queue", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
